dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Data-memory responder for the pipelined MIPS core. It is the target end of the core's memory-access interface, and the core acts as initiator.
- Accepts one load or store request at a time over a valid/ready handshake. Each request is answered after a programmable number of wait states.
- Each committed store produces a one-cycle write-log record for the bench's store trace.
- Sits beside the core in the top-level harness, replacing the zero-latency array memory so stall logic can be exercised.

Parameters:
- ADDR_W, 12, word-index width; capacity is 2^ADDR_W 32-bit words (16 KiB).
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- WAIT_CYCLES, 0, extra cycles between acceptance and response; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; bits [1:0] are ignored for indexing.
- req_be  in  4  byte enables; bit i selects byte lane i (little-endian lanes).
- req_wdata  in  32  store data, lane-aligned.
- req_pc  in  32  PC of the issuing instruction; used only for the write log.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  full word read; 0 on error or on a store.
- rsp_err  out  1  qualified by rsp_valid; indicates an out-of-range address or illegal be.
- wr_log_valid  out  1  one-cycle pulse when a store commits.
- wr_log_pc  out  32  req_pc of the committed store.
- wr_log_addr  out  32  word-aligned byte address, i.e. {req_addr[31:2], 2'b00}.
- wr_log_data  out  32  full merged word after the store.

Behaviour:
- Reset:
  - Reset is synchronous and active-low: when reset is 0 at a clk edge, the state goes to IDLE.
  - req_ready becomes 1; rsp_valid, rsp_err and wr_log_valid become 0.
  - rsp_rdata and all wr_log_* outputs become 0.
  - Every memory word is cleared to 0.
- FSM states: IDLE, WAIT, RESP.
  - In IDLE, req_ready=1. When req_valid=1, the request is latched into holding registers. The next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
  - In WAIT, req_ready=0. A 4-bit counter counts WAIT_CYCLES cycles, then the FSM moves to RESP.
  - In RESP, req_ready=0 and rsp_valid=1 for exactly one cycle. The store commits to the array on this edge. The FSM then returns to IDLE.
- Latency and throughput:
  - The response appears WAIT_CYCLES+1 cycles after the acceptance edge.
  - Maximum throughput is one request per WAIT_CYCLES+2 cycles.
  - A request held across RESP is accepted on the first IDLE cycle after it.
- Request capture: inputs are sampled only at acceptance. Changes on req_* during WAIT or RESP are ignored.
- Legal be values: 0001, 0010, 0100, 1000, 0011, 1100, 1111. Any other be gives rsp_err=1. This applies to loads and stores alike.
- Range check: the address is in range iff BASE_ADDR <= req_addr < BASE_ADDR + 4*2^ADDR_W, computed with a 33-bit unsigned compare so there is no wrap-around. Out of range gives rsp_err=1.
- On error: no memory write, no wr_log pulse, rsp_rdata=0.
- Loads: rsp_rdata is the full word at index (req_addr-BASE_ADDR)>>2, as read at the RESP edge. be does not mask the data; the core extracts the bytes it needs.
- Stores:
  - The new word is formed per lane: req_wdata for enabled lanes, the old memory contents for the others.
  - That merged word is written to the array, and wr_log_data carries the same merged word.
  - wr_log_valid pulses in the same cycle as rsp_valid, with rsp_rdata=0.
- Reset mid-operation (reset low in WAIT or RESP):
  - The request is aborted and nothing is committed.
  - No rsp_valid or wr_log_valid is produced.
  - The FSM returns to IDLE.
- No combinational path from req_* to rsp_* or wr_log_*; all outputs come from registers. req_ready is decoded from the state register.

Decomposition:
- Shared package dm_pkg holds:
  - the FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - the legal-be constants;
  - the function be_merge(old, wdata, be).
- One sub-module, dm_array: a 2^ADDR_W x 32 word store with synchronous clear, one write port with byte-lane enables and one read port. The FSM, range/be checking and log registers stay in dm_responder.

Test Plan:
1. Store then load, WAIT_CYCLES=0.
   - Stimulus: store addr=0x10, be=1111, wdata=0xDEADBEEF, pc=0x3000, then load 0x10.
   - Required: rsp_valid 1 cycle after each acceptance; wr_log = (0x3000, 0x10, 0xDEADBEEF); load rsp_rdata=0xDEADBEEF, rsp_err=0.
2. Byte-lane merge.
   - Stimulus: after scenario 1, store addr=0x12, be=0100, wdata=0x00AA0000.
   - Required: wr_log_data=0xDEAABEEF; a following load of 0x10 returns 0xDEAABEEF.
3. Wait states, WAIT_CYCLES=3.
   - Stimulus: load accepted at cycle t, with req_valid held high throughout.
   - Required: req_ready=0 for t+1..t+4; rsp_valid at t+4; next acceptance at t+5.
4. Errors.
   - Stimulus: store at 0x4000 (first out-of-range address with ADDR_W=12); then load with be=0101.
   - Required: both give rsp_err=1 and rsp_rdata=0; no wr_log pulse; a load of 0x0 still returns 0.
5. Reset mid-operation, WAIT_CYCLES=2.
   - Stimulus: store addr=0x20, data=0x12345678; reset driven low during WAIT for one edge.
   - Required: no rsp_valid or wr_log_valid; req_ready=1 after release; a load of 0x20 returns 0.
6. Reset clears memory.
   - Stimulus: fill 0x0 and 0x3FFC with 0xFFFFFFFF, then apply a one-cycle reset.
   - Required: both loads return 0.

Source files
------------

// File: rtl/dm_pkg.sv
// ============================================================================
// dm_pkg: shared FSM encoding, legal byte-enable patterns and lane merge.
// Rev 1.0
// ============================================================================
`default_nettype none

package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_e;

  localparam logic [3:0] BE_BYTE0 = 4'b0001;
  localparam logic [3:0] BE_BYTE1 = 4'b0010;
  localparam logic [3:0] BE_BYTE2 = 4'b0100;
  localparam logic [3:0] BE_BYTE3 = 4'b1000;
  localparam logic [3:0] BE_HALF0 = 4'b0011;
  localparam logic [3:0] BE_HALF1 = 4'b1100;
  localparam logic [3:0] BE_WORD  = 4'b1111;

  function automatic logic be_legal(input logic [3:0] be);
    return (be == BE_BYTE0) || (be == BE_BYTE1) || (be == BE_BYTE2) ||
           (be == BE_BYTE3) || (be == BE_HALF0) || (be == BE_HALF1) ||
           (be == BE_WORD);
  endfunction

  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dm_array.sv
// ============================================================================
// dm_array: 2^ADDR_W x 32 word store, synchronous clear, byte-lane write port.
// Rev 1.0
// ============================================================================
`default_nettype none

module dm_array #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              clear_n_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [3:0]        wbe_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!clear_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/dm_responder.sv
// ============================================================================
// dm_responder: data-memory target with programmable wait states and store log.
// Rev 1.0
// ============================================================================
`default_nettype none

module dm_responder
  import dm_pkg::*;
#(
  parameter int          ADDR_W      = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        wr_log_valid,
  output logic [31:0] wr_log_pc,
  output logic [31:0] wr_log_addr,
  output logic [31:0] wr_log_data
);

  localparam logic [3:0]  WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic [32:0] SPAN      = 33'd4 << ADDR_W;

  dm_state_e state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;

  logic              we_q;
  logic [31:2]       addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [31:0]       pc_q;
  logic [ADDR_W-1:0] idx_q;
  logic              err_q;

  logic        rsp_valid_q, rsp_err_q, wr_log_valid_q;
  logic [31:0] rsp_rdata_q, wr_log_pc_q, wr_log_addr_q, wr_log_data_q;

  logic              accept;
  logic              enter_resp;
  logic [31:0]       offset;
  logic              in_range;
  logic              req_err;
  logic [ADDR_W-1:0] req_idx;
  logic              unused_offset_bits;

  logic              cur_we;
  logic [31:2]       cur_addr;
  logic [3:0]        cur_be;
  logic [31:0]       cur_wdata;
  logic [31:0]       cur_pc;
  logic [ADDR_W-1:0] cur_idx;
  logic              cur_err;
  logic [31:0]       arr_rdata;
  logic              commit;

  assign accept   = (state_q == IDLE) && req_valid;
  assign offset   = req_addr - BASE_ADDR;
  assign req_idx  = offset[ADDR_W+1:2];
  assign unused_offset_bits = ^{offset[31:ADDR_W+2], offset[1:0]};
  // 33-bit compare keeps the window from wrapping past 4 GiB.
  assign in_range = ({1'b0, req_addr} >= {1'b0, BASE_ADDR}) &&
                    ({1'b0, req_addr} <  ({1'b0, BASE_ADDR} + SPAN));
  assign req_err  = !in_range || !be_legal(req_be);

  // With no wait states the response is built on the acceptance edge itself,
  // so the live request is used then; otherwise the held copy.
  assign cur_we    = accept ? req_we         : we_q;
  assign cur_addr  = accept ? req_addr[31:2] : addr_q;
  assign cur_be    = accept ? req_be         : be_q;
  assign cur_wdata = accept ? req_wdata      : wdata_q;
  assign cur_pc    = accept ? req_pc         : pc_q;
  assign cur_idx   = accept ? req_idx        : idx_q;
  assign cur_err   = accept ? req_err        : err_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = (WAIT_CYCLES > 0) ? WAIT : RESP;
          wcnt_d  = '0;
        end
      end
      WAIT: begin
        if (wcnt_q == WAIT_LAST) state_d = RESP;
        else                     wcnt_d  = wcnt_q + 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign enter_resp = (state_d == RESP);

  always_ff @(posedge clk) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr[31:2];
      be_q    <= req_be;
      wdata_q <= req_wdata;
      pc_q    <= req_pc;
      idx_q   <= req_idx;
      err_q   <= req_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_valid_q    <= 1'b0;
      rsp_err_q      <= 1'b0;
      rsp_rdata_q    <= '0;
      wr_log_valid_q <= 1'b0;
      wr_log_pc_q    <= '0;
      wr_log_addr_q  <= '0;
      wr_log_data_q  <= '0;
    end else begin
      rsp_valid_q    <= enter_resp;
      wr_log_valid_q <= enter_resp && cur_we && !cur_err;
      if (enter_resp) begin
        rsp_err_q   <= cur_err;
        rsp_rdata_q <= (cur_we || cur_err) ? 32'd0 : arr_rdata;
        if (cur_we && !cur_err) begin
          wr_log_pc_q   <= cur_pc;
          wr_log_addr_q <= {cur_addr, 2'b00};
          wr_log_data_q <= be_merge(arr_rdata, cur_wdata, cur_be);
        end
      end
    end
  end

  // The merged word lands in the array on the edge that ends RESP, so a reset
  // during RESP still aborts the commit.
  assign commit = (state_q == RESP) && wr_log_valid_q;

  dm_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk       (clk),
    .clear_n_i (reset),
    .we_i      (commit),
    .waddr_i   (idx_q),
    .wbe_i     (be_q),
    .wdata_i   (wr_log_data_q),
    .raddr_i   (cur_idx),
    .rdata_o   (arr_rdata)
  );

  assign rsp_valid    = rsp_valid_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign wr_log_valid = wr_log_valid_q;
  assign wr_log_pc    = wr_log_pc_q;
  assign wr_log_addr  = wr_log_addr_q;
  assign wr_log_data  = wr_log_data_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_responder.sv
// ============================================================================
// tb_dm_responder: three responders (0/3/2 wait states) against a word-array model.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dm_responder;

  localparam int NDUT  = 3;
  localparam int WORDS = 4096;

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
  endfunction

  function automatic logic [31:0] base_of(input int k);
    return (k == 2) ? 32'h0001_0000 : 32'h0000_0000;
  endfunction

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        logv;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid    [NDUT];
  logic        req_ready    [NDUT];
  logic        req_we       [NDUT];
  logic [31:0] req_addr     [NDUT];
  logic [3:0]  req_be       [NDUT];
  logic [31:0] req_wdata    [NDUT];
  logic [31:0] req_pc       [NDUT];
  logic        rsp_valid    [NDUT];
  logic [31:0] rsp_rdata    [NDUT];
  logic        rsp_err      [NDUT];
  logic        wr_log_valid [NDUT];
  logic [31:0] wr_log_pc    [NDUT];
  logic [31:0] wr_log_addr  [NDUT];
  logic [31:0] wr_log_data  [NDUT];

  exp_t        sb  [NDUT][$];
  logic [31:0] mdl [NDUT][WORDS];
  int          last_acc  [NDUT];
  bit          last_hold [NDUT];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dm_responder #(
      .ADDR_W      (12),
      .BASE_ADDR   ((g == 2) ? 32'h0001_0000 : 32'h0000_0000),
      .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 3 : 2))
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_we       (req_we[g]),
      .req_addr     (req_addr[g]),
      .req_be       (req_be[g]),
      .req_wdata    (req_wdata[g]),
      .req_pc       (req_pc[g]),
      .rsp_valid    (rsp_valid[g]),
      .rsp_rdata    (rsp_rdata[g]),
      .rsp_err      (rsp_err[g]),
      .wr_log_valid (wr_log_valid[g]),
      .wr_log_pc    (wr_log_pc[g]),
      .wr_log_addr  (wr_log_addr[g]),
      .wr_log_data  (wr_log_data[g])
    );

    always @(negedge clk) begin
      exp_t e;
      if (reset) begin
        if (rsp_valid[g]) begin
          if (sb[g].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_rsp dut%0d actual=1 required=0", g);
          end else begin
            e = sb[g].pop_front();
            chk($sformatf("rdata_dut%0d", g),   rsp_rdata[g], e.rdata);
            chk($sformatf("err_dut%0d", g),     32'(rsp_err[g]), 32'(e.err));
            chk($sformatf("logv_dut%0d", g),    32'(wr_log_valid[g]), 32'(e.logv));
            chk($sformatf("latency_dut%0d", g), 32'(cyc - e.acc), 32'(wait_of(g) + 1));
            if (e.logv) begin
              chk($sformatf("log_pc_dut%0d", g),   wr_log_pc[g],   e.pc);
              chk($sformatf("log_addr_dut%0d", g), wr_log_addr[g], e.addr);
              chk($sformatf("log_data_dut%0d", g), wr_log_data[g], e.data);
            end
          end
        end else if (wr_log_valid[g]) begin
          checks++;
          failures++;
          $display("FAIL stray_wr_log dut%0d actual=1 required=0", g);
        end
      end
    end
  end

  task automatic scramble(input int k);
    req_valid[k] = 1'b0;
    req_we[k]    = 1'($urandom);
    req_addr[k]  = $urandom;
    req_be[k]    = 4'($urandom);
    req_wdata[k] = $urandom;
    req_pc[k]    = $urandom;
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input int k, input bit we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata,
                       input logic [31:0] pc, input bit hold);
    exp_t   e;
    int     n;
    longint off;
    int     idx;
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_be[k]    = be;
    req_wdata[k] = wdata;
    req_pc[k]    = pc;
    n = 0;
    while (!req_ready[k] && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[k]) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout dut%0d actual=ready_low required=ready_high", k);
      scramble(k);
      return;
    end
    if (last_hold[k]) chk($sformatf("throughput_dut%0d", k), 32'(cyc - last_acc[k]), 32'(wait_of(k) + 2));
    last_acc[k]  = cyc;
    last_hold[k] = hold;

    off     = longint'(addr) - longint'(base_of(k));
    e.acc   = cyc;
    e.err   = !((off >= 0) && (off < 4 * WORDS) &&
                (be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111}));
    e.rdata = 32'd0;
    e.logv  = 1'b0;
    e.pc    = 32'd0;
    e.addr  = 32'd0;
    e.data  = 32'd0;
    if (!e.err) begin
      idx = int'(off / 4);
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mdl[k][idx][8*b +: 8] = wdata[8*b +: 8];
        end
        e.logv = 1'b1;
        e.pc   = pc;
        e.addr = {addr[31:2], 2'b00};
        e.data = mdl[k][idx];
      end else begin
        e.rdata = mdl[k][idx];
      end
    end
    sb[k].push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (!hold) scramble(k);
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while (sb[k].size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb[k].size() != 0) begin
      checks++;
      failures++;
      $display("FAIL rsp_timeout dut%0d actual=%0d_pending required=0", k, sb[k].size());
      sb[k].delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      sb[k].delete();
      last_hold[k] = 1'b0;
      for (int i = 0; i < WORDS; i++) mdl[k][i] = 32'd0;
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("rst_ready_dut%0d", k),    32'(req_ready[k]), 32'd1);
      chk($sformatf("rst_rspv_dut%0d", k),     32'(rsp_valid[k]), 32'd0);
      chk($sformatf("rst_err_dut%0d", k),      32'(rsp_err[k]), 32'd0);
      chk($sformatf("rst_rdata_dut%0d", k),    rsp_rdata[k], 32'd0);
      chk($sformatf("rst_logv_dut%0d", k),     32'(wr_log_valid[k]), 32'd0);
      chk($sformatf("rst_logpc_dut%0d", k),    wr_log_pc[k], 32'd0);
      chk($sformatf("rst_logaddr_dut%0d", k),  wr_log_addr[k], 32'd0);
      chk($sformatf("rst_logdata_dut%0d", k),  wr_log_data[k], 32'd0);
    end
  endtask

  task automatic random_ops(input int k, input int count);
    logic [3:0]  legal [7];
    logic [31:0] addr;
    logic [3:0]  be;
    int          r;
    bit          hold;
    legal = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    for (int i = 0; i < count; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       addr = base_of(k) + 32'(4 * $urandom_range(0, 15) + $urandom_range(0, 3));
      else if (r == 6) addr = base_of(k) + 32'(4 * $urandom_range(4092, 4095) + $urandom_range(0, 3));
      else if (r == 7) addr = base_of(k) + 32'h4000 + 32'($urandom_range(0, 7));
      else if (r == 8) addr = base_of(k) - 32'(4 * $urandom_range(1, 2));
      else             addr = $urandom;
      if ($urandom_range(0, 3) != 0) be = legal[$urandom_range(0, 6)];
      else                           be = 4'($urandom_range(0, 15));
      hold = (i != count - 1) && ($urandom_range(0, 1) == 1);
      issue(k, 1'($urandom), addr, be, $urandom, $urandom, hold);
    end
    drain(k);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      scramble(k);
      last_acc[k] = 0;
    end
    @(negedge clk);
    do_reset();

    // Store/load, byte-lane merge and error handling with zero wait states.
    issue(0, 1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF, 32'h3000, 1'b0); drain(0);
    issue(0, 1'b0, 32'h10, 4'b1111, 32'h0, 32'h3004, 1'b0);         drain(0);
    issue(0, 1'b1, 32'h12, 4'b0100, 32'h00AA_0000, 32'h3008, 1'b0); drain(0);
    issue(0, 1'b0, 32'h10, 4'b1111, 32'h0, 32'h300C, 1'b0);         drain(0);
    issue(0, 1'b1, 32'h4000, 4'b1111, 32'h1111_2222, 32'h3010, 1'b0); drain(0);
    issue(0, 1'b0, 32'h10, 4'b0101, 32'h0, 32'h3014, 1'b0);         drain(0);
    issue(0, 1'b0, 32'h0, 4'b1111, 32'h0, 32'h3018, 1'b0);          drain(0);

    // Back-to-back loads with three wait states and req_valid held high.
    issue(1, 1'b1, 32'h14, 4'b0011, 32'hCAFE_F00D, 32'h100, 1'b0);  drain(1);
    issue(1, 1'b0, 32'h14, 4'b1111, 32'h0, 32'h104, 1'b1);
    issue(1, 1'b0, 32'h10, 4'b1111, 32'h0, 32'h108, 1'b1);
    issue(1, 1'b0, 32'h3FFC, 4'b1000, 32'h0, 32'h10C, 1'b0);       drain(1);

    // Reset during WAIT aborts the store.
    issue(2, 1'b1, base_of(2) + 32'h20, 4'b1111, 32'h1234_5678, 32'h200, 1'b0);
    do_reset();
    repeat (4) @(negedge clk);
    issue(2, 1'b0, base_of(2) + 32'h20, 4'b1111, 32'h0, 32'h204, 1'b0); drain(2);

    // Reset clears the whole array, including the last word.
    issue(0, 1'b1, 32'h0,    4'b1111, 32'hFFFF_FFFF, 32'h400, 1'b0); drain(0);
    issue(0, 1'b1, 32'h3FFC, 4'b1111, 32'hFFFF_FFFF, 32'h404, 1'b0); drain(0);
    issue(0, 1'b0, 32'h3FFC, 4'b1111, 32'h0, 32'h408, 1'b0);         drain(0);
    do_reset();
    issue(0, 1'b0, 32'h0,    4'b1111, 32'h0, 32'h40C, 1'b0);         drain(0);
    issue(0, 1'b0, 32'h3FFC, 4'b1111, 32'h0, 32'h410, 1'b0);         drain(0);

    for (int k = 0; k < NDUT; k++) random_ops(k, 120);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
